// File: rtl/syn_but_wing_pm.sv
// Radix-2 FFT/IFFT butterfly: data_0 = a + b*w, data_1 = a - b*w, serialised on one port.
// Pipelined complex multiply, optional per-sample twiddle conjugate, divide-by-2 scaling and saturation.
module syn_but_wing_pm #(
  parameter int P_SAMPLE_W = 16,
  parameter int P_TWDL_W   = 10,
  parameter int P_MUL_LAT  = 3
) (
  input  logic                  clk_ir,
  input  logic                  rst_sync,
  input  logic                  sample_rdy,
  output logic                  in_ready,
  input  logic [P_SAMPLE_W-1:0] sample_a_re,
  input  logic [P_SAMPLE_W-1:0] sample_a_im,
  input  logic [P_SAMPLE_W-1:0] sample_b_re,
  input  logic [P_SAMPLE_W-1:0] sample_b_im,
  input  logic [P_TWDL_W-1:0]   twdl_re,
  input  logic [P_TWDL_W-1:0]   twdl_im,
  input  logic                  cfg_ifft,
  input  logic                  cfg_scale,
  output logic [P_SAMPLE_W-1:0] res_re,
  output logic [P_SAMPLE_W-1:0] res_im,
  output logic                  res_rdy,
  output logic                  res_idx,
  output logic                  res_sat,
  output logic                  in_ovrflw
);

  localparam int MW = P_SAMPLE_W + P_TWDL_W;
  localparam int PW = MW + 1;
  localparam int NW = P_SAMPLE_W + 1;
  localparam int SW = P_SAMPLE_W + 2;
  localparam int SH = P_TWDL_W - 2;

  function automatic logic signed [P_TWDL_W-1:0] neg_sat_tw(input logic signed [P_TWDL_W-1:0] x);
    logic signed [P_TWDL_W-1:0] min_v;
    min_v = {1'b1, {(P_TWDL_W-1){1'b0}}};
    if (x == min_v) neg_sat_tw = ~min_v;
    else            neg_sat_tw = -x;
  endfunction

  function automatic logic signed [SW-1:0] sum_scale(input logic signed [P_SAMPLE_W-1:0] a,
                                                     input logic signed [SW-1:0] n,
                                                     input logic scl);
    logic signed [SW-1:0] s;
    s = {{2{a[P_SAMPLE_W-1]}}, a} + n;
    sum_scale = scl ? (s >>> 1) : s;
  endfunction

  // Returns {clipped, value}; in range only when the top three bits agree.
  function automatic logic [P_SAMPLE_W:0] sat_s(input logic signed [SW-1:0] s);
    logic [2:0] top;
    top = s[SW-1:P_SAMPLE_W-1];
    if (top == 3'b000 || top == 3'b111) sat_s = {1'b0, s[P_SAMPLE_W-1:0]};
    else if (!s[SW-1])                  sat_s = {2'b10, {(P_SAMPLE_W-1){1'b1}}};
    else                                sat_s = {2'b11, {(P_SAMPLE_W-1){1'b0}}};
  endfunction

  logic                         accept;
  logic signed [P_SAMPLE_W-1:0] b_re_s, b_im_s;
  logic signed [P_TWDL_W-1:0]   w_re_s, w_im_s;
  logic signed [MW-1:0]         rr, ii, ri, ir;
  logic signed [PW-1:0]         prod_re_c, prod_im_c;

  assign accept = sample_rdy & in_ready;
  assign b_re_s = sample_b_re;
  assign b_im_s = sample_b_im;
  assign w_re_s = twdl_re;
  assign w_im_s = cfg_ifft ? neg_sat_tw(twdl_im) : twdl_im;
  assign rr = b_re_s * w_re_s;
  assign ii = b_im_s * w_im_s;
  assign ri = b_re_s * w_im_s;
  assign ir = b_im_s * w_re_s;
  assign prod_re_c = {rr[MW-1], rr} - {ii[MW-1], ii};
  assign prod_im_c = {ri[MW-1], ri} + {ir[MW-1], ir};

  // Stage p0: multiplier pipeline with a-sample and scale delay line
  logic signed [PW-1:0]         p_re_p0 [P_MUL_LAT];
  logic signed [PW-1:0]         p_im_p0 [P_MUL_LAT];
  logic signed [P_SAMPLE_W-1:0] a_re_p0 [P_MUL_LAT];
  logic signed [P_SAMPLE_W-1:0] a_im_p0 [P_MUL_LAT];
  logic                         scl_p0  [P_MUL_LAT];
  logic [P_MUL_LAT-1:0]         vld_p0;

  always_ff @(posedge clk_ir) begin
    p_re_p0[0] <= prod_re_c;
    p_im_p0[0] <= prod_im_c;
    a_re_p0[0] <= sample_a_re;
    a_im_p0[0] <= sample_a_im;
    scl_p0[0]  <= cfg_scale;
    for (int i = 1; i < P_MUL_LAT; i++) begin
      p_re_p0[i] <= p_re_p0[i-1];
      p_im_p0[i] <= p_im_p0[i-1];
      a_re_p0[i] <= a_re_p0[i-1];
      a_im_p0[i] <= a_im_p0[i-1];
      scl_p0[i]  <= scl_p0[i-1];
    end
  end

  // Stage p1: normalise; held until the next sample so data_1 can reuse -n
  logic signed [PW-1:0]         sh_re, sh_im;
  logic signed [SW-1:0]         nx_re, nx_im;
  logic signed [SW-1:0]         n_re_p1, n_im_p1, nn_re_p1, nn_im_p1;
  logic signed [P_SAMPLE_W-1:0] a_re_p1, a_im_p1;
  logic                         scl_p1;
  logic                         vld_p1, vld_p2;

  assign sh_re = p_re_p0[P_MUL_LAT-1] >>> SH;
  assign sh_im = p_im_p0[P_MUL_LAT-1] >>> SH;
  assign nx_re = {sh_re[NW-1], sh_re[NW-1:0]};
  assign nx_im = {sh_im[NW-1], sh_im[NW-1:0]};

  always_ff @(posedge clk_ir) begin
    if (vld_p0[P_MUL_LAT-1]) begin
      n_re_p1  <= nx_re;
      n_im_p1  <= nx_im;
      nn_re_p1 <= -nx_re;
      nn_im_p1 <= -nx_im;
      a_re_p1  <= a_re_p0[P_MUL_LAT-1];
      a_im_p1  <= a_im_p0[P_MUL_LAT-1];
      scl_p1   <= scl_p0[P_MUL_LAT-1];
    end
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      in_ready  <= 1'b1;
      in_ovrflw <= 1'b0;
      vld_p0    <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      in_ready  <= ~accept;
      in_ovrflw <= sample_rdy & ~in_ready;
      vld_p0[0] <= accept;
      for (int i = 1; i < P_MUL_LAT; i++) vld_p0[i] <= vld_p0[i-1];
      vld_p1    <= vld_p0[P_MUL_LAT-1];
      vld_p2    <= vld_p1;
    end
  end

  // Stage p2: sum, scale, saturate; data_0 when vld_p1, data_1 one cycle later
  logic signed [SW-1:0] sel_re, sel_im;
  logic [P_SAMPLE_W:0]  sat_re_c, sat_im_c;
  logic                 out_vld;

  assign out_vld  = vld_p1 | vld_p2;
  assign sel_re   = vld_p1 ? n_re_p1 : nn_re_p1;
  assign sel_im   = vld_p1 ? n_im_p1 : nn_im_p1;
  assign sat_re_c = sat_s(sum_scale(a_re_p1, sel_re, scl_p1));
  assign sat_im_c = sat_s(sum_scale(a_im_p1, sel_im, scl_p1));

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      res_re  <= '0;
      res_im  <= '0;
      res_rdy <= 1'b0;
      res_idx <= 1'b0;
      res_sat <= 1'b0;
    end else begin
      res_rdy <= out_vld;
      res_idx <= vld_p2;
      res_sat <= out_vld & (sat_re_c[P_SAMPLE_W] | sat_im_c[P_SAMPLE_W]);
      if (out_vld) begin
        res_re <= sat_re_c[P_SAMPLE_W-1:0];
        res_im <= sat_im_c[P_SAMPLE_W-1:0];
      end
    end
  end

endmodule
